char_rom_arb: RTL and testbench
===============================

# char_rom_arb

Two-port arbiter that shares the single-read-port character glyph ROM (10-bit address, 144-bit glyph row) between two overlay renderers in the display path, e.g. the on-screen text renderer and the axis-label renderer. It accepts at most one address per cycle, drives the ROM address, and tracks each in-flight read through the ROM's fixed read latency. It returns the data only to the requester that issued it. It sits directly in front of the ROM instance; the ROM is used with no output register, so its latency is 1.

## Interface
- ADDR_WIDTH, 10, ROM address width.
- DATA_WIDTH, 144, ROM data width.
- ROM_LATENCY, 1, cycles from the clock edge that samples the address to valid ROM data. Legal values are 1 and 2; use 2 when the ROM output register is enabled.
- PRIO_MODE, 0, arbitration mode. 0 = round-robin; 1 = fixed priority, with port 0 winning.
- clk  in  1  single clock, shared with the ROM.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  ADDR_WIDTH  port 0 read address.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 read data valid; one-cycle pulse.
- rsp0_data  out  DATA_WIDTH  port 0 read data; held between pulses.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as port 0, for port 1.
- rom_addr  out  ADDR_WIDTH  address to the ROM.
- rom_rd_data  in  DATA_WIDTH  data from the ROM.
- conflict_cnt  out  16  saturating count of cycles in which both reqN_valid were high.

## Operation
- Accept rule: request N is accepted in any cycle where reqN_valid && reqN_ready. At most one port has ready high in a cycle.
- Ready logic: reqN_ready is combinational from the valids and the priority pointer.
  - Only one valid high: that port is ready.
  - Both valid: the port with priority is ready. In PRIO_MODE=1 this is always port 0. In PRIO_MODE=0 it is the port not granted most recently.
  - Neither valid: both ready low.
- Priority pointer (PRIO_MODE=0): updates only on an accept, to point at the other port.
  - A lone requester may win on consecutive cycles; the pointer toggles back each time it wins.
  - With both ports valid continuously, grants alternate 0,1,0,1.
- ROM address: rom_addr is combinational. It equals the winning reqN_addr in an accept cycle. Otherwise it equals the last accepted address, held in a register, so the ROM input does not toggle while idle.
- Tag pipeline: ROM_LATENCY stages, each holding {valid, port_id}.
  - Stage 0 loads {accept, winner} at every clock edge.
  - The entry leaving the last stage qualifies rom_rd_data in that cycle.
- Response capture: when the tag leaving the last stage is valid, its port's rspN_data register loads rom_rd_data. rspN_valid goes high for the next cycle. The other port's rsp_data is unchanged.
- No response backpressure: requesters must sink every response.
- Throughput is one read per cycle, sustained.
- conflict_cnt increments on every cycle with req0_valid && req1_valid. It saturates at 16'hFFFF.
- Arbitration is the only state machine: a 1-bit pointer with states LAST0 and LAST1. Reset state is LAST1, so port 0 wins the first conflict.

## Timing
- Latency: a request accepted in cycle t gives rspN_valid high in cycle t+ROM_LATENCY+1 (2 cycles for the default).
- The response carries the ROM word at the accepted address.
- Back-to-back accepts in cycles t, t+1 give responses in consecutive cycles, in the same order.
- Reset values (asserted asynchronously): rsp0_valid=0, rsp1_valid=0, rsp0_data=0, rsp1_data=0, held address=0, all tag stages invalid, pointer=LAST1, conflict_cnt=0.
- rom_addr=0 and both ready low while the valids are low.
- Reset mid-operation discards all in-flight reads. No rsp_valid is produced for them after reset is released.
- Requests presented while rst is high are not accepted: both ready are forced low during reset.
- Simultaneous request arrival is resolved within the same cycle, with no bubble. The losing port keeps its valid and address stable until it sees ready.
- Address wrap: address 2**ADDR_WIDTH-1 is an ordinary address and needs no special handling.

## Test plan
- Bench ROM model: returns {134'b0, addr} with the configured ROM_LATENCY.
- Single port: req0 addresses 0..1023 back to back, req1 idle.
  - req0_ready is high every cycle.
  - rsp0 returns 0..1023 in order, each 2 cycles after accept.
  - rsp1_valid never goes high; conflict_cnt stays 0.
- Round-robin contention (PRIO_MODE=0): both ports valid for 8 cycles; port 0 presents 0x010 then 0x011 after each grant, port 1 presents 0x200 then 0x201.
  - Grant order is 0,1,0,1,…
  - rsp0 returns 0x010, 0x011, …; rsp1 returns 0x200, 0x201, …
  - conflict_cnt = 8.
- Fixed priority (PRIO_MODE=1): both ports valid for 5 cycles, then port 0 drops.
  - Port 1 gets no grant for 5 cycles, then is granted on the 6th.
  - Port 1's data is 0x200.
- Reset mid-flight: accept 0x055 on port 0, then assert rst on the next cycle for 3 cycles.
  - All outputs return to their reset values immediately.
  - No rsp0_valid appears after release.
  - The first conflict after release grants port 0.
- ROM_LATENCY=2 build: interleaved single accepts on 0x3FF (port 1) and 0x000 (port 0).
  - Responses arrive 3 cycles after each accept, to the correct port.
  - rom_addr holds 0x000 while idle.
- Saturation: force 70000 conflict cycles; conflict_cnt reaches 16'hFFFF and stays there.

Source files
------------

// File: rtl/char_rom_arb_if.sv
// Bundle of the two requester ports, the ROM port and the conflict counter
// shared between the glyph ROM arbiter and whatever drives it.
interface char_rom_arb_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 144
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic                  req0_ready;
   logic                  rsp0_valid;
   logic [DATA_WIDTH-1:0] rsp0_data;

   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic                  req1_ready;
   logic                  rsp1_valid;
   logic [DATA_WIDTH-1:0] rsp1_data;

   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_rd_data;
   logic [15:0]           conflict_cnt;

   // Requesters plus the ROM instance.
   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr, rom_rd_data,
      input  req0_ready, rsp0_valid, rsp0_data,
             req1_ready, rsp1_valid, rsp1_data,
             rom_addr, conflict_cnt
   );

   // The arbiter itself.
   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr, rom_rd_data,
      output req0_ready, rsp0_valid, rsp0_data,
             req1_ready, rsp1_valid, rsp1_data,
             rom_addr, conflict_cnt
   );
endinterface

// File: rtl/char_rom_arb.sv
// Shares the single read port of the character glyph ROM between two overlay
// renderers. One address is accepted per cycle; a {valid, port} tag follows
// each read through the ROM latency so the data returns only to its issuer.
module char_rom_arb #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 144,
   parameter int ROM_LATENCY = 1,   // 1, or 2 with the ROM output register on
   parameter int PRIO_MODE   = 0    // 0 = round-robin, 1 = port 0 always wins
) (
   input logic           clk,
   input logic           rst,
   char_rom_arb_if.slave bus
);

   typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} prio_state_e;

   typedef struct packed {
      logic valid;
      logic port;
   } tag_t;

   prio_state_e           state_q, state_d;
   logic                  grant0, grant1, accept, port0_prio;
   logic [ADDR_WIDTH-1:0] held_addr;
   tag_t                  tag_q [ROM_LATENCY];
   tag_t                  tag_out;
   logic [DATA_WIDTH-1:0] rsp0_data_q, rsp1_data_q;
   logic                  rsp0_valid_q, rsp1_valid_q;
   logic [15:0]           conflict_q;

   assign accept  = grant0 | grant1;
   assign tag_out = tag_q[ROM_LATENCY-1];

   // Priority pointer register; LAST1 after reset so port 0 wins the first conflict.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments in clocked blocks keep every flop
      // sampling pre-edge values, independent of statement order.
      if (rst) state_q <= LAST1;
      else     state_q <= state_d;
   end

   // Grant decision and pointer next state; no grants while reset is high.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      grant0     = 1'b0;
      grant1     = 1'b0;
      port0_prio = (PRIO_MODE == 1) || (state_q == LAST1);
      if (!rst) begin
         if (bus.req0_valid && (!bus.req1_valid || port0_prio)) grant0 = 1'b1;
         else if (bus.req1_valid)                               grant1 = 1'b1;
      end
      if (grant0)      state_d = LAST0;
      else if (grant1) state_d = LAST1;
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // The winner's address goes straight through; otherwise the last accepted
   // address is replayed so the ROM input stays quiet while idle.
   assign bus.rom_addr = grant0 ? bus.req0_addr :
                         grant1 ? bus.req1_addr : held_addr;

   // Remember the last accepted address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         held_addr <= '0;
      else if (accept) held_addr <= bus.rom_addr;
   end

   // Tag pipeline, one stage per cycle of ROM latency.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the tag stages are reset, unlike a data memory would be, because
      // a stale valid bit would fabricate a response after reset.
      if (rst) begin
         for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_t'{valid: accept, port: grant1};
         for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Capture ROM data for the port named by the tag leaving the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         rsp0_valid_q <= tag_out.valid && !tag_out.port;
         rsp1_valid_q <= tag_out.valid &&  tag_out.port;
         if (tag_out.valid && !tag_out.port) rsp0_data_q <= bus.rom_rd_data;
         if (tag_out.valid &&  tag_out.port) rsp1_data_q <= bus.rom_rd_data;
      end
   end

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp1_data  = rsp1_data_q;

   // Saturating count of cycles with both ports requesting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         conflict_q <= '0;
      else if (bus.req0_valid && bus.req1_valid && conflict_q != 16'hFFFF)
         conflict_q <= conflict_q + 16'd1;
   end

   assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_char_rom_arb.sv
// Directed bench for char_rom_arb: three builds (round-robin, fixed priority,
// ROM latency 2), each behind a ROM model returning {134'b0, addr}.
module tb_char_rom_arb;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   char_rom_arb_if rr_if ();
   char_rom_arb_if fp_if ();
   char_rom_arb_if l2_if ();

   char_rom_arb #(.ROM_LATENCY(1), .PRIO_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(rr_if));
   char_rom_arb #(.ROM_LATENCY(1), .PRIO_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(fp_if));
   char_rom_arb #(.ROM_LATENCY(2), .PRIO_MODE(0)) dut_l2 (.clk(clk), .rst(rst), .bus(l2_if));

   // ROM models: address registered once (latency 1) or twice (latency 2).
   logic [9:0] rr_rom_q, fp_rom_q, l2_rom_q1, l2_rom_q2;
   always @(posedge clk) begin
      rr_rom_q  <= rr_if.rom_addr;
      fp_rom_q  <= fp_if.rom_addr;
      l2_rom_q1 <= l2_if.rom_addr;
      l2_rom_q2 <= l2_rom_q1;
   end
   assign rr_if.rom_rd_data = {134'b0, rr_rom_q};
   assign fp_if.rom_rd_data = {134'b0, fp_rom_q};
   assign l2_if.rom_rd_data = {134'b0, l2_rom_q2};

   function automatic logic [143:0] word(input int a);
      return {134'b0, 10'(a)};
   endfunction

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rr_if.req0_valid = 1'b1; rr_if.req1_valid = 1'b1;
      fp_if.req0_valid = 1'b1; fp_if.req1_valid = 1'b1;
      l2_if.req0_valid = 1'b1; l2_if.req1_valid = 1'b1;
      #1;
      checks++;
      if ({rr_if.req0_ready, rr_if.req1_ready, fp_if.req0_ready, fp_if.req1_ready,
           l2_if.req0_ready, l2_if.req1_ready} !== 6'b0) begin
         errors++; $display("FAIL ready_in_reset: got %b%b%b%b%b%b want 000000",
            rr_if.req0_ready, rr_if.req1_ready, fp_if.req0_ready, fp_if.req1_ready,
            l2_if.req0_ready, l2_if.req1_ready);
      end
      checks++;
      if ({rr_if.rsp0_valid, rr_if.rsp1_valid} !== 2'b00) begin
         errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", rr_if.rsp0_valid, rr_if.rsp1_valid);
      end
      checks++;
      if (rr_if.rsp0_data !== '0 || rr_if.rsp1_data !== '0) begin
         errors++; $display("FAIL reset_rsp_data: got %h / %h want 0", rr_if.rsp0_data, rr_if.rsp1_data);
      end
      checks++;
      if (rr_if.conflict_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_conflict_cnt: got %h want 0000", rr_if.conflict_cnt);
      end
      checks++;
      if (rr_if.rom_addr !== 10'h000) begin
         errors++; $display("FAIL reset_rom_addr: got %h want 000", rr_if.rom_addr);
      end
      rr_if.req0_valid = 1'b0; rr_if.req1_valid = 1'b0;
      fp_if.req0_valid = 1'b0; fp_if.req1_valid = 1'b0;
      l2_if.req0_valid = 1'b0; l2_if.req1_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rr_if.req0_ready !== 1'b0 || rr_if.req1_ready !== 1'b0 || rr_if.rom_addr !== 10'h000) begin
         errors++; $display("FAIL idle_after_reset: ready=%b%b rom_addr=%h want 00 / 000",
            rr_if.req0_ready, rr_if.req1_ready, rr_if.rom_addr);
      end
   endtask

   task automatic test_single_port();
      for (int c = 0; c <= 1026; c++) begin
         @(negedge clk);
         rr_if.req0_valid = (c < 1024);
         rr_if.req0_addr  = 10'(c);
         rr_if.req1_valid = 1'b0;
         #1;
         if (c < 1024) begin
            checks++;
            if (rr_if.req0_ready !== 1'b1 || rr_if.req1_ready !== 1'b0) begin
               errors++; $display("FAIL single_ready c=%0d: got %b%b want 10", c, rr_if.req0_ready, rr_if.req1_ready);
            end
         end
         checks++;
         if (rr_if.rom_addr !== 10'((c < 1024) ? c : 1023)) begin
            errors++; $display("FAIL single_rom_addr c=%0d: got %h want %h", c, rr_if.rom_addr, 10'((c < 1024) ? c : 1023));
         end
         checks++;
         if (rr_if.rsp0_valid !== (c >= 2 && c <= 1025) || rr_if.rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_valid c=%0d: got %b%b want %b0", c, rr_if.rsp0_valid, rr_if.rsp1_valid, (c >= 2 && c <= 1025));
         end
         if (c >= 2 && c <= 1025) begin
            checks++;
            if (rr_if.rsp0_data !== word(c - 2)) begin
               errors++; $display("FAIL single_rsp_data c=%0d: got %h want %h", c, rr_if.rsp0_data, word(c - 2));
            end
         end
      end
      checks++;
      if (rr_if.conflict_cnt !== 16'h0) begin
         errors++; $display("FAIL single_conflict_cnt: got %h want 0000", rr_if.conflict_cnt);
      end
   endtask

   task automatic test_round_robin();
      bit even;
      pulse_reset();
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         rr_if.req0_valid = (c < 8);
         rr_if.req1_valid = (c < 8);
         rr_if.req0_addr  = 10'(16'h010 + (c + 1) / 2);
         rr_if.req1_addr  = 10'(16'h200 + c / 2);
         #1;
         even = (c % 2 == 0);
         if (c < 8) begin
            checks++;
            if (rr_if.req0_ready !== even || rr_if.req1_ready !== !even) begin
               errors++; $display("FAIL rr_grant c=%0d: got %b%b want %b%b", c, rr_if.req0_ready, rr_if.req1_ready, even, !even);
            end
            checks++;
            if (rr_if.rom_addr !== (even ? rr_if.req0_addr : rr_if.req1_addr)) begin
               errors++; $display("FAIL rr_rom_addr c=%0d: got %h want %h", c, rr_if.rom_addr, even ? rr_if.req0_addr : rr_if.req1_addr);
            end
         end
         checks++;
         if (rr_if.rsp0_valid !== (c >= 2 && c <= 9 && even) || rr_if.rsp1_valid !== (c >= 2 && c <= 9 && !even)) begin
            errors++; $display("FAIL rr_rsp_valid c=%0d: got %b%b", c, rr_if.rsp0_valid, rr_if.rsp1_valid);
         end
         if (c >= 2 && c <= 9) begin
            checks++;
            if (even && rr_if.rsp0_data !== word(16'h010 + (c - 2) / 2)) begin
               errors++; $display("FAIL rr_rsp0_data c=%0d: got %h want %h", c, rr_if.rsp0_data, word(16'h010 + (c - 2) / 2));
            end else if (!even && rr_if.rsp1_data !== word(16'h200 + (c - 2) / 2)) begin
               errors++; $display("FAIL rr_rsp1_data c=%0d: got %h want %h", c, rr_if.rsp1_data, word(16'h200 + (c - 2) / 2));
            end
         end
      end
      checks++;
      if (rr_if.conflict_cnt !== 16'd8) begin
         errors++; $display("FAIL rr_conflict_cnt: got %0d want 8", rr_if.conflict_cnt);
      end
   endtask

   task automatic test_reset_mid_flight();
      @(negedge clk);
      rr_if.req0_valid = 1'b1; rr_if.req0_addr = 10'h055;
      #1;
      checks++;
      if (rr_if.req0_ready !== 1'b1) begin
         errors++; $display("FAIL mid_accept: got ready0=%b want 1", rr_if.req0_ready);
      end
      @(negedge clk);
      rr_if.req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({rr_if.rsp0_valid, rr_if.rsp1_valid} !== 2'b00 || rr_if.rsp0_data !== '0 || rr_if.rsp1_data !== '0) begin
         errors++; $display("FAIL mid_rsp_reset: got valid=%b%b data=%h/%h want 00 and 0",
            rr_if.rsp0_valid, rr_if.rsp1_valid, rr_if.rsp0_data, rr_if.rsp1_data);
      end
      checks++;
      if (rr_if.conflict_cnt !== 16'h0 || rr_if.rom_addr !== 10'h000) begin
         errors++; $display("FAIL mid_state_reset: got cnt=%h rom_addr=%h want 0000/000", rr_if.conflict_cnt, rr_if.rom_addr);
      end
      repeat (2) @(negedge clk);
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         checks++;
         if (rr_if.rsp0_valid !== 1'b0 || rr_if.rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_rsp k=%0d: got %b%b want 00", k, rr_if.rsp0_valid, rr_if.rsp1_valid);
         end
      end
      @(negedge clk);
      rr_if.req0_valid = 1'b1; rr_if.req0_addr = 10'h0AA;
      rr_if.req1_valid = 1'b1; rr_if.req1_addr = 10'h0BB;
      #1;
      checks++;
      if (rr_if.req0_ready !== 1'b1 || rr_if.req1_ready !== 1'b0 || rr_if.rom_addr !== 10'h0AA) begin
         errors++; $display("FAIL mid_first_conflict: got ready=%b%b rom_addr=%h want 10 / 0aa",
            rr_if.req0_ready, rr_if.req1_ready, rr_if.rom_addr);
      end
      @(negedge clk);
      rr_if.req0_valid = 1'b0; rr_if.req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rr_if.rsp0_valid !== 1'b1 || rr_if.rsp0_data !== word(16'h0AA)) begin
         errors++; $display("FAIL mid_post_rsp: got valid=%b data=%h want 1 / %h", rr_if.rsp0_valid, rr_if.rsp0_data, word(16'h0AA));
      end
   endtask

   task automatic test_fixed_priority();
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         fp_if.req0_valid = (c < 5);
         fp_if.req1_valid = (c < 6);
         fp_if.req0_addr  = 10'(16'h100 + c);
         fp_if.req1_addr  = 10'h200;
         #1;
         if (c < 6) begin
            checks++;
            if (fp_if.req0_ready !== (c < 5) || fp_if.req1_ready !== (c == 5)) begin
               errors++; $display("FAIL fp_grant c=%0d: got %b%b want %b%b", c, fp_if.req0_ready, fp_if.req1_ready, (c < 5), (c == 5));
            end
         end
         checks++;
         if (fp_if.rsp1_valid !== (c == 7) || fp_if.rsp0_valid !== (c >= 2 && c <= 6)) begin
            errors++; $display("FAIL fp_rsp_valid c=%0d: got %b%b", c, fp_if.rsp0_valid, fp_if.rsp1_valid);
         end
         if (c == 7) begin
            checks++;
            if (fp_if.rsp1_data !== word(16'h200)) begin
               errors++; $display("FAIL fp_rsp1_data: got %h want %h", fp_if.rsp1_data, word(16'h200));
            end
         end
         if (c >= 2 && c <= 6) begin
            checks++;
            if (fp_if.rsp0_data !== word(16'h100 + c - 2)) begin
               errors++; $display("FAIL fp_rsp0_data c=%0d: got %h want %h", c, fp_if.rsp0_data, word(16'h100 + c - 2));
            end
         end
      end
      checks++;
      if (fp_if.conflict_cnt !== 16'd5) begin
         errors++; $display("FAIL fp_conflict_cnt: got %0d want 5", fp_if.conflict_cnt);
      end
   endtask

   task automatic test_latency2();
      logic [8:0] v0_tab    = 9'b0_0001_0010;
      logic [8:0] v1_tab    = 9'b0_0000_1001;
      logic [8:0] rsp0_tab  = 9'b0_1001_0000;
      logic [8:0] rsp1_tab  = 9'b0_0100_1000;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         l2_if.req0_valid = v0_tab[c]; l2_if.req0_addr = 10'h000;
         l2_if.req1_valid = v1_tab[c]; l2_if.req1_addr = 10'h3FF;
         #1;
         checks++;
         if (l2_if.req0_ready !== v0_tab[c] || l2_if.req1_ready !== v1_tab[c]) begin
            errors++; $display("FAIL l2_ready c=%0d: got %b%b want %b%b", c, l2_if.req0_ready, l2_if.req1_ready, v0_tab[c], v1_tab[c]);
         end
         checks++;
         if (l2_if.rom_addr !== (v1_tab[c] ? 10'h3FF : 10'h000)) begin
            errors++; $display("FAIL l2_rom_addr c=%0d: got %h want %h", c, l2_if.rom_addr, v1_tab[c] ? 10'h3FF : 10'h000);
         end
         checks++;
         if (l2_if.rsp0_valid !== rsp0_tab[c] || l2_if.rsp1_valid !== rsp1_tab[c]) begin
            errors++; $display("FAIL l2_rsp_valid c=%0d: got %b%b want %b%b", c, l2_if.rsp0_valid, l2_if.rsp1_valid, rsp0_tab[c], rsp1_tab[c]);
         end
         if (c >= 3) begin
            checks++;
            if (l2_if.rsp1_data !== word(16'h3FF) || l2_if.rsp0_data !== word(0)) begin
               errors++; $display("FAIL l2_rsp_data c=%0d: got %h / %h", c, l2_if.rsp0_data, l2_if.rsp1_data);
            end
         end
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      @(negedge clk);
      fp_if.req0_valid = 1'b1; fp_if.req0_addr = 10'h123;
      fp_if.req1_valid = 1'b1; fp_if.req1_addr = 10'h321;
      #1;
      checks++;
      if (fp_if.conflict_cnt !== 16'h0000) begin
         errors++; $display("FAIL sat_start: got %h want 0000", fp_if.conflict_cnt);
      end
      repeat (65534) @(negedge clk);
      #1;
      checks++;
      if (fp_if.conflict_cnt !== 16'hFFFE) begin
         errors++; $display("FAIL sat_fffe: got %h want fffe", fp_if.conflict_cnt);
      end
      @(negedge clk); #1;
      checks++;
      if (fp_if.conflict_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL sat_ffff: got %h want ffff", fp_if.conflict_cnt);
      end
      repeat (4465) @(negedge clk);
      #1;
      checks++;
      if (fp_if.conflict_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold: got %h want ffff", fp_if.conflict_cnt);
      end
      fp_if.req0_valid = 1'b0; fp_if.req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (fp_if.conflict_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL sat_idle: got %h want ffff", fp_if.conflict_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      rr_if.req0_valid = 1'b0; rr_if.req0_addr = '0; rr_if.req1_valid = 1'b0; rr_if.req1_addr = '0;
      fp_if.req0_valid = 1'b0; fp_if.req0_addr = '0; fp_if.req1_valid = 1'b0; fp_if.req1_addr = '0;
      l2_if.req0_valid = 1'b0; l2_if.req0_addr = '0; l2_if.req1_valid = 1'b0; l2_if.req1_addr = '0;
      test_reset();
      test_single_port();
      test_round_robin();
      test_reset_mid_flight();
      test_fixed_priority();
      test_latency2();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
